// File: rtl/reg_file_multiport.sv
// Multi-read, single-write register file with a hard-wired zero entry and a self-timed clear sweep.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_multiport #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_READ*ADDR_W-1:0] READ_REG,
  output logic [NUM_READ*DATA_W-1:0] DATA_OUT,
  input  logic [ADDR_W-1:0]          WRITE_REG,
  input  logic [DATA_W-1:0]          WRITE_DATA,
  input  logic                       REG_WRITE_ENABLE,
  input  logic                       CLEAR_REQ,
  output logic                       BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              busy_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_fire;

  assign wr_fire = (state_reg == IDLE) && REG_WRITE_ENABLE && (WRITE_REG != ZERO_IDX);
  assign BUSY    = busy_reg;

  // Reset restarts the sweep from entry 0 even if one is already running.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (CLEAR_REQ) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= CLEAR;
          cnt_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  // The sweep and the user write share the single write port; they never overlap in state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_reg == CLEAR) begin
        mem[cnt_reg] <= '0;
      end else if (wr_fire) begin
        mem[WRITE_REG] <= WRITE_DATA;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi = gi + 1) begin : g_read
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] rdata;

      assign raddr = READ_REG[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rdata = mem[raddr];
        if (busy_reg || (raddr == ZERO_IDX)) begin
          rdata = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        else if (wr_fire && (raddr == WRITE_REG)) begin
          rdata = WRITE_DATA;
        end
`endif
      end

      assign DATA_OUT[gi*DATA_W +: DATA_W] = rdata;
    end
  endgenerate

endmodule
